bpu_upd_sched: RTL and testbench

Update scheduler for the tournament branch predictor. It accepts resolved-branch records from the execute stage through a valid/ready handshake and buffers them in a small FIFO. It then issues at most one predictor update per cycle, driving the BTB, PHT and chooser (eval) update strobes with registered outputs. It decouples execute-stage timing from the predictor write ports and lets the pipeline back-pressure when updates pile up.

---
 rtl/bpu_upd_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_bpu_upd_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_upd_sched.sv
// bpu_upd_sched: update scheduler for the tournament branch predictor.
// Resolved-branch records enter through a valid/ready handshake and are
// filtered and stored in a small FIFO. At most one entry is drained per
// cycle into registered BTB / PHT / chooser update strobes.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_br_*  / o_br_rdy    resolved-branch record input and handshake
//   i_hold                pause draining (queue keeps accepting)
//   i_clr                 synchronous discard of queued and issuing records
//   o_upd_btb_*           BTB write strobe, PC and target
//   o_upd_pht_* / eval    PHT/GHR and chooser update strobes and fields
//   o_q_count             FIFO occupancy
//
// Optional feature macro: BPU_UPD_PERF_CNT_EN
//   Adds o_cnt_cond / o_cnt_mispred saturating performance counters and
//   stores the fetch-time final prediction with each record.
module bpu_upd_sched #(
  parameter  int unsigned PC_WIDTH = 32,
  parameter  int unsigned Q_DEPTH  = 4,
  localparam int unsigned Q_ADDR_W = $clog2(Q_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_br_vld,
  output logic                o_br_rdy,
  input  logic [PC_WIDTH-1:0] i_br_pc,
  input  logic [PC_WIDTH-1:0] i_br_target,
  input  logic                i_br_taken,
  input  logic                i_br_is_cond,
  input  logic                i_br_pred_hit,
  input  logic                i_br_pred_taken,
  input  logic                i_br_pred_glb,
  input  logic                i_br_pred_loc,
  input  logic                i_hold,
  input  logic                i_clr,
  output logic                o_upd_btb_vld,
  output logic [PC_WIDTH-1:0] o_upd_btb_pc,
  output logic [PC_WIDTH-1:0] o_upd_btb_br_addr,
  output logic                o_upd_pht_vld,
  output logic                o_upd_eval_vld,
  output logic [PC_WIDTH-1:0] o_upd_pht_pc,
  output logic                o_upd_pht_taken,
  output logic                o_upd_pht_pred_glb_taken,
  output logic                o_upd_pht_pred_loc_taken,
`ifdef BPU_UPD_PERF_CNT_EN
  output logic [31:0]         o_cnt_cond,
  output logic [31:0]         o_cnt_mispred,
`endif
  output logic [Q_ADDR_W:0]   o_q_count
);

  localparam int unsigned CNT_W = Q_ADDR_W + 1;

  // One stored record; actions are pre-decoded at accept time.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target;
    logic                taken;
    logic                btb_act;
    logic                pht_act;
    logic                eval_act;
    logic                pred_glb;
    logic                pred_loc;
`ifdef BPU_UPD_PERF_CNT_EN
    logic                pred_taken;
`endif
  } entry_t;

  entry_t              mem_q [Q_DEPTH];
  logic [Q_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [Q_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  entry_t              in_entry_c;
  entry_t              head_c;
  logic                full_c;
  logic                any_act_c;
  logic                push_c;
  logic                pop_c;

  // Output register
  logic                btb_vld_q, btb_vld_d;
  logic                pht_vld_q, pht_vld_d;
  logic                eval_vld_q, eval_vld_d;
  logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
  logic [PC_WIDTH-1:0] upd_tgt_q, upd_tgt_d;
  logic                upd_taken_q, upd_taken_d;
  logic                upd_glb_q, upd_glb_d;
  logic                upd_loc_q, upd_loc_d;

`ifndef BPU_UPD_PERF_CNT_EN
  // The final prediction is only needed by the performance counters.
  logic unused_pred_taken;
  assign unused_pred_taken = i_br_pred_taken;
`endif

  // Record decode and handshake
  always_comb begin
    in_entry_c          = '0;
    in_entry_c.pc       = i_br_pc;
    in_entry_c.target   = i_br_target;
    in_entry_c.taken    = i_br_taken;
    in_entry_c.btb_act  = i_br_taken;
    in_entry_c.pht_act  = i_br_is_cond;
    in_entry_c.eval_act = i_br_is_cond & i_br_pred_hit;
    in_entry_c.pred_glb = i_br_pred_glb;
    in_entry_c.pred_loc = i_br_pred_loc;
`ifdef BPU_UPD_PERF_CNT_EN
    in_entry_c.pred_taken = i_br_pred_taken;
`endif
  end

  assign full_c    = (count_q == CNT_W'(Q_DEPTH));
  assign o_br_rdy  = ~full_c & ~i_clr;
  assign any_act_c = in_entry_c.btb_act | in_entry_c.pht_act | in_entry_c.eval_act;
  // Records with no action are acknowledged but never stored.
  assign push_c    = i_br_vld & o_br_rdy & any_act_c;
  assign pop_c     = (count_q != '0) & ~i_hold & ~i_clr;
  assign head_c    = mem_q[rd_ptr_q];

  // Pointer / occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + Q_ADDR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + Q_ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_entry_c;
  end

  // Update output next state: strobes pulse per pop, fields hold otherwise
  always_comb begin
    btb_vld_d   = 1'b0;
    pht_vld_d   = 1'b0;
    eval_vld_d  = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_tgt_d   = upd_tgt_q;
    upd_taken_d = upd_taken_q;
    upd_glb_d   = upd_glb_q;
    upd_loc_d   = upd_loc_q;
    if (pop_c) begin
      btb_vld_d   = head_c.btb_act;
      pht_vld_d   = head_c.pht_act;
      eval_vld_d  = head_c.eval_act;
      upd_pc_d    = head_c.pc;
      upd_tgt_d   = head_c.target;
      upd_taken_d = head_c.taken;
      upd_glb_d   = head_c.pred_glb;
      upd_loc_d   = head_c.pred_loc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btb_vld_q   <= 1'b0;
      pht_vld_q   <= 1'b0;
      eval_vld_q  <= 1'b0;
      upd_pc_q    <= '0;
      upd_tgt_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_glb_q   <= 1'b0;
      upd_loc_q   <= 1'b0;
    end else begin
      btb_vld_q   <= btb_vld_d;
      pht_vld_q   <= pht_vld_d;
      eval_vld_q  <= eval_vld_d;
      upd_pc_q    <= upd_pc_d;
      upd_tgt_q   <= upd_tgt_d;
      upd_taken_q <= upd_taken_d;
      upd_glb_q   <= upd_glb_d;
      upd_loc_q   <= upd_loc_d;
    end
  end

  assign o_upd_btb_vld            = btb_vld_q;
  assign o_upd_pht_vld            = pht_vld_q;
  assign o_upd_eval_vld           = eval_vld_q;
  assign o_upd_btb_pc             = upd_pc_q;
  assign o_upd_pht_pc             = upd_pc_q;
  assign o_upd_btb_br_addr        = upd_tgt_q;
  assign o_upd_pht_taken          = upd_taken_q;
  assign o_upd_pht_pred_glb_taken = upd_glb_q;
  assign o_upd_pht_pred_loc_taken = upd_loc_q;
  assign o_q_count                = count_q;

`ifdef BPU_UPD_PERF_CNT_EN
  // Saturating pop-time counters, cleared by reset and i_clr
  logic [31:0] cnt_cond_q, cnt_cond_d;
  logic [31:0] cnt_misp_q, cnt_misp_d;

  always_comb begin
    cnt_cond_d = cnt_cond_q;
    cnt_misp_d = cnt_misp_q;
    if (i_clr) begin
      cnt_cond_d = '0;
      cnt_misp_d = '0;
    end else if (pop_c) begin
      if (head_c.pht_act && (cnt_cond_q != '1))
        cnt_cond_d = cnt_cond_q + 32'd1;
      if ((head_c.pred_taken != head_c.taken) && (cnt_misp_q != '1))
        cnt_misp_d = cnt_misp_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_cond_q <= '0;
      cnt_misp_q <= '0;
    end else begin
      cnt_cond_q <= cnt_cond_d;
      cnt_misp_q <= cnt_misp_d;
    end
  end

  assign o_cnt_cond    = cnt_cond_q;
  assign o_cnt_mispred = cnt_misp_q;
`endif

endmodule

// File: tb/tb_bpu_upd_sched.sv
// Self-checking bench for bpu_upd_sched: randomized records against a
// queue-based reference model, with a scoreboard monitor on the strobes.
module tb_bpu_upd_sched;

  localparam int QD = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        is_cond;
    logic        hit;
    logic        ptaken;
    logic        glb;
    logic        loc;
  } rec_t;

  logic        clk, rst_n;
  logic        i_br_vld, i_br_taken, i_br_is_cond, i_br_pred_hit;
  logic        i_br_pred_taken, i_br_pred_glb, i_br_pred_loc, i_hold, i_clr;
  logic [31:0] i_br_pc, i_br_target;
  logic        o_br_rdy, o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld;
  logic [31:0] o_upd_btb_pc, o_upd_btb_br_addr, o_upd_pht_pc;
  logic        o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken;
  logic [2:0]  o_q_count;
`ifdef BPU_UPD_PERF_CNT_EN
  logic [31:0] o_cnt_cond, o_cnt_mispred;
  int unsigned m_cond, m_misp;
`endif

  int   checks = 0;
  int   failures = 0;
  rec_t mq[$];       // records the model holds in the queue
  rec_t exp_out[$];  // records expected on the strobes next cycle
  rec_t last;        // last issued record (fields must hold)

  bpu_upd_sched dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_br_vld(i_br_vld), .o_br_rdy(o_br_rdy),
    .i_br_pc(i_br_pc), .i_br_target(i_br_target),
    .i_br_taken(i_br_taken), .i_br_is_cond(i_br_is_cond),
    .i_br_pred_hit(i_br_pred_hit), .i_br_pred_taken(i_br_pred_taken),
    .i_br_pred_glb(i_br_pred_glb), .i_br_pred_loc(i_br_pred_loc),
    .i_hold(i_hold), .i_clr(i_clr),
    .o_upd_btb_vld(o_upd_btb_vld), .o_upd_btb_pc(o_upd_btb_pc),
    .o_upd_btb_br_addr(o_upd_btb_br_addr),
    .o_upd_pht_vld(o_upd_pht_vld), .o_upd_eval_vld(o_upd_eval_vld),
    .o_upd_pht_pc(o_upd_pht_pc), .o_upd_pht_taken(o_upd_pht_taken),
    .o_upd_pht_pred_glb_taken(o_upd_pht_pred_glb_taken),
    .o_upd_pht_pred_loc_taken(o_upd_pht_pred_loc_taken),
`ifdef BPU_UPD_PERF_CNT_EN
    .o_cnt_cond(o_cnt_cond), .o_cnt_mispred(o_cnt_mispred),
`endif
    .o_q_count(o_q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc      = $urandom;
    r.tgt     = $urandom;
    r.taken   = 1'($urandom_range(0, 1));
    r.is_cond = 1'($urandom_range(0, 1));
    r.hit     = 1'($urandom_range(0, 1));
    r.ptaken  = 1'($urandom_range(0, 1));
    r.glb     = 1'($urandom_range(0, 1));
    r.loc     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic taken, input logic is_cond, input logic hit,
                              input logic ptaken, input logic glb, input logic loc);
    rec_t r;
    r.pc = pc; r.tgt = tgt; r.taken = taken; r.is_cond = is_cond;
    r.hit = hit; r.ptaken = ptaken; r.glb = glb; r.loc = loc;
    return r;
  endfunction

  // Expected strobe/field vector for an issued record
  function automatic logic [101:0] exp_vec(input rec_t r);
    return {r.taken, r.is_cond, r.is_cond & r.hit, r.pc, r.tgt, r.pc, r.taken, r.glb, r.loc};
  endfunction

  function automatic void model_reset();
    rec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mq.delete();
    exp_out.delete();
    last = z;
`ifdef BPU_UPD_PERF_CNT_EN
    m_cond = 0;
    m_misp = 0;
`endif
  endfunction

  // One cycle: drive at negedge, check handshake state, apply model at posedge.
  task automatic step(input logic vld, input rec_t r, input logic hold, input logic clr);
    logic mrdy;
    rec_t h;
    i_br_vld = vld; i_br_pc = r.pc; i_br_target = r.tgt; i_br_taken = r.taken;
    i_br_is_cond = r.is_cond; i_br_pred_hit = r.hit; i_br_pred_taken = r.ptaken;
    i_br_pred_glb = r.glb; i_br_pred_loc = r.loc; i_hold = hold; i_clr = clr;
    #1;
    mrdy = (mq.size() != QD) && !clr;
    chk("br_rdy", 128'(o_br_rdy), 128'(mrdy));
    chk("q_count", 128'(o_q_count), 128'(mq.size()));
`ifdef BPU_UPD_PERF_CNT_EN
    chk("cnt_cond", 128'(o_cnt_cond), 128'(m_cond));
    chk("cnt_mispred", 128'(o_cnt_mispred), 128'(m_misp));
`endif
    @(posedge clk);
    if (clr) begin
      mq.delete();
`ifdef BPU_UPD_PERF_CNT_EN
      m_cond = 0;
      m_misp = 0;
`endif
    end else begin
      if (mq.size() != 0 && !hold) begin
        h = mq.pop_front();
        exp_out.push_back(h);
`ifdef BPU_UPD_PERF_CNT_EN
        if (h.is_cond && m_cond != 32'hffff_ffff) m_cond++;
        if (h.ptaken != h.taken && m_misp != 32'hffff_ffff) m_misp++;
`endif
      end
      if (vld && mrdy && (r.taken || r.is_cond)) mq.push_back(r);
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: every strobe cycle must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_upd_btb_vld || o_upd_pht_vld || o_upd_eval_vld) begin
        if (exp_out.size() == 0) begin
          chk("unexpected_strobe", 128'({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}), 128'(0));
        end else begin
          last = exp_out.pop_front();
          chk("update", 128'({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld, o_upd_btb_pc,
                              o_upd_btb_br_addr, o_upd_pht_pc, o_upd_pht_taken,
                              o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}),
              128'(exp_vec(last)));
        end
      end else begin
        if (exp_out.size() != 0) begin
          chk("missing_strobe", 128'(0), 128'(exp_vec(exp_out[0])));
          void'(exp_out.pop_front());
        end
        chk("fields_hold", 128'({o_upd_btb_pc, o_upd_btb_br_addr, o_upd_pht_pc, o_upd_pht_taken,
                                 o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}),
            128'({last.pc, last.tgt, last.pc, last.taken, last.glb, last.loc}));
      end
    end
  end

  initial begin
    rec_t idle;
    int   hold_pct;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    i_br_vld = 0; i_br_pc = 0; i_br_target = 0; i_br_taken = 0; i_br_is_cond = 0;
    i_br_pred_hit = 0; i_br_pred_taken = 0; i_br_pred_glb = 0; i_br_pred_loc = 0;
    i_hold = 0; i_clr = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_count", 128'(o_q_count), 128'(0));
    chk("reset_strobes", 128'({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single conditional taken record; strobes appear two cycles later
    step(1, mk(32'h100, 32'h180, 1, 1, 1, 1, 1, 0), 0, 0);
    step(0, idle, 0, 0);
    #1;
    chk("first_update", 128'({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld, o_upd_btb_br_addr,
                              o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken}),
        128'({3'b111, 32'h180, 3'b110}));
    step(0, idle, 0, 0);

    // Fill under hold, then a full-queue push attempt alongside the first pop
    for (int i = 0; i < 4; i++) step(1, rand_rec(), 1, 0);
    step(1, mk(32'h200, 32'h240, 1, 0, 0, 1, 0, 0), 1, 0);
    step(1, mk(32'h300, 32'h340, 1, 1, 0, 1, 0, 1), 0, 0);
    step(1, mk(32'h300, 32'h340, 1, 1, 0, 1, 0, 1), 0, 0);
    repeat (6) step(0, idle, 0, 0);

    // Filtered record, then pht-only record
    step(1, mk(32'h400, 32'h480, 0, 0, 1, 0, 1, 1), 0, 0);
    step(1, mk(32'h500, 32'h580, 0, 1, 0, 0, 0, 1), 0, 0);
    repeat (3) step(0, idle, 0, 0);

    // Three queued, then clear with a concurrent valid record
    for (int i = 0; i < 3; i++) step(1, mk(32'h600 + i, 32'h700, 1, 1, 1, 0, 0, 0), 1, 0);
    step(1, rand_rec(), 0, 1);
    repeat (3) step(0, idle, 0, 0);

    // Five conditional pops, two mispredicted (counters start from a clear)
    step(0, idle, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, mk(32'h800 + i, 32'h900, 1, 1, 1, (i < 2) ? 1'b0 : 1'b1, 1, 1), 0, 0);
    repeat (3) step(0, idle, 0, 0);
`ifdef BPU_UPD_PERF_CNT_EN
    chk("perf_cond5", 128'(o_cnt_cond), 128'(5));
    chk("perf_misp2", 128'(o_cnt_mispred), 128'(2));
`endif

    // Randomized traffic in segments with varying hold pressure
    for (int seg = 0; seg < 8; seg++) begin
      hold_pct = (seg % 4) * 25;
      for (int c = 0; c < 200; c++)
        step(1'($urandom_range(0, 2) != 0), rand_rec(),
             1'($urandom_range(0, 99) < hold_pct), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, mk(32'ha00 + i, 32'hb00, 1, 1, 1, 0, 1, 0), i == 0, 0);
    #3;
    rst_n = 1'b0;
    i_br_vld = 0;
    #1;
    model_reset();
    chk("arst_count", 128'(o_q_count), 128'(0));
    chk("arst_strobes", 128'({o_upd_btb_vld, o_upd_pht_vld, o_upd_eval_vld}), 128'(0));
`ifdef BPU_UPD_PERF_CNT_EN
    chk("arst_cnts", 128'({o_cnt_cond, o_cnt_mispred}), 128'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, idle, 0, 0);
    chk("drained", 128'(exp_out.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
